// File: rtl/inst_mem_pipe.sv
// Pipelined instruction memory: valid/ready fetch of FETCH_N consecutive words with LAT-cycle latency,
// whole-pipe stall on response backpressure, flush, per-slot fault flagging and a preload write port.
module inst_mem_pipe #(
  parameter int unsigned          ADDR_W   = 64,
  parameter int unsigned          INST_W   = 32,
  parameter int unsigned          MAX_INST = 256,
  parameter int unsigned          LAT      = 3,
  parameter int unsigned          FETCH_N  = 1,
  parameter logic [INST_W-1:0]    NOP      = 32'h0000_0013
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_req_vld,
  output logic                          o_req_rdy,
  input  logic [ADDR_W-1:0]             i_addr,
  input  logic                          i_flush,
  output logic                          o_rsp_vld,
  input  logic                          i_rsp_rdy,
  output logic [FETCH_N*INST_W-1:0]     o_inst,
  output logic [FETCH_N-1:0]            o_err,
  input  logic                          i_wr_en,
  input  logic [$clog2(MAX_INST)-1:0]   i_wr_idx,
  input  logic [INST_W-1:0]             i_wr_data
);

  localparam int unsigned IDX_W  = $clog2(MAX_INST);
  localparam int unsigned SLOT_W = ADDR_W - 2;

  logic [INST_W-1:0]         r_mem   [MAX_INST];
  logic                      r_vld   [LAT];
  logic [FETCH_N*INST_W-1:0] r_inst  [LAT];
  logic [FETCH_N-1:0]        r_err   [LAT];

  logic                      w_nvld  [LAT];
  logic [FETCH_N*INST_W-1:0] w_ninst [LAT];
  logic [FETCH_N-1:0]        w_nerr  [LAT];

  logic                      w_stall;
  logic                      w_acc;
  logic [FETCH_N*INST_W-1:0] w_inst;
  logic [FETCH_N-1:0]        w_err;

  assign w_stall   = o_rsp_vld & ~i_rsp_rdy;
  assign o_req_rdy = ~w_stall;
  assign w_acc     = i_req_vld & ~w_stall & ~i_flush;

  // Full-width index keeps out-of-range addresses from aliasing into the array.
  for (genvar k = 0; k < FETCH_N; k++) begin : g_slot
    logic [SLOT_W-1:0] w_idx;
    logic              w_bad;
    assign w_idx    = i_addr[ADDR_W-1:2] + SLOT_W'(k);
    assign w_bad    = (i_addr[1:0] != 2'b00) || (w_idx >= SLOT_W'(MAX_INST));
    assign w_err[k] = w_bad;
    assign w_inst[k*INST_W +: INST_W] = w_bad ? NOP : r_mem[w_idx[IDX_W-1:0]];
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_idx] <= i_wr_data;
  end

  for (genvar s = 0; s < LAT; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign w_nvld[s]  = w_acc;
      assign w_ninst[s] = w_inst;
      assign w_nerr[s]  = w_err;
    end else begin : g_tail
      assign w_nvld[s]  = r_vld[s-1];
      assign w_ninst[s] = r_inst[s-1];
      assign w_nerr[s]  = r_err[s-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_vld[s]  <= 1'b0;
        r_inst[s] <= '0;
        r_err[s]  <= '0;
      end else if (i_flush) begin
        r_vld[s]  <= 1'b0;
      end else if (!w_stall) begin
        r_vld[s]  <= w_nvld[s];
        r_inst[s] <= w_ninst[s];
        r_err[s]  <= w_nerr[s];
      end
    end
  end

  assign o_rsp_vld = r_vld[LAT-1];
  assign o_inst    = r_inst[LAT-1];
  assign o_err     = r_err[LAT-1];

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Bench for inst_mem_pipe: three configurations driven by shared stimulus, each checked against
// an in-order token scoreboard where entries age on unstalled edges and surface at age LAT.
module tb_inst_mem_pipe;

  localparam int          NDUT = 3;
  localparam int          MAXI = 256;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct {
    int          age;
    logic [63:0] inst;
    logic [1:0]  err;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_vld, flush, rsp_rdy, wr_en;
  logic [63:0] addr;
  logic [7:0]  wr_idx;
  logic [31:0] wr_data;

  logic        vld0, vld1, vld2, rdy0, rdy1, rdy2;
  logic [31:0] inst0;
  logic [63:0] inst1, inst2;
  logic [0:0]  err0;
  logic [1:0]  err1, err2;

  logic [31:0] mmem [MAXI];
  ent_t        mq   [NDUT][$];
  int          n_cmp = 0;
  int          n_mis = 0;

  always #5 clk = ~clk;

  inst_mem_pipe #(.ADDR_W(64), .INST_W(32), .MAX_INST(MAXI), .LAT(3), .FETCH_N(1), .NOP(NOP)) u_d0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_vld(req_vld), .o_req_rdy(rdy0), .i_addr(addr),
    .i_flush(flush), .o_rsp_vld(vld0), .i_rsp_rdy(rsp_rdy), .o_inst(inst0), .o_err(err0),
    .i_wr_en(wr_en), .i_wr_idx(wr_idx), .i_wr_data(wr_data));

  inst_mem_pipe #(.ADDR_W(64), .INST_W(32), .MAX_INST(MAXI), .LAT(1), .FETCH_N(2), .NOP(NOP)) u_d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_vld(req_vld), .o_req_rdy(rdy1), .i_addr(addr),
    .i_flush(flush), .o_rsp_vld(vld1), .i_rsp_rdy(rsp_rdy), .o_inst(inst1), .o_err(err1),
    .i_wr_en(wr_en), .i_wr_idx(wr_idx), .i_wr_data(wr_data));

  inst_mem_pipe #(.ADDR_W(64), .INST_W(32), .MAX_INST(MAXI), .LAT(8), .FETCH_N(2), .NOP(NOP)) u_d2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_vld(req_vld), .o_req_rdy(rdy2), .i_addr(addr),
    .i_flush(flush), .o_rsp_vld(vld2), .i_rsp_rdy(rsp_rdy), .o_inst(inst2), .o_err(err2),
    .i_wr_en(wr_en), .i_wr_idx(wr_idx), .i_wr_data(wr_data));

  function automatic int lat_of(input int d);
    return (d == 0) ? 3 : (d == 1) ? 1 : 8;
  endfunction

  function automatic int fn_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic get_vld(input int d);
    return (d == 0) ? vld0 : (d == 1) ? vld1 : vld2;
  endfunction

  function automatic logic get_rdy(input int d);
    return (d == 0) ? rdy0 : (d == 1) ? rdy1 : rdy2;
  endfunction

  function automatic logic [63:0] get_inst(input int d);
    return (d == 0) ? {32'h0, inst0} : (d == 1) ? inst1 : inst2;
  endfunction

  function automatic logic [1:0] get_err(input int d);
    return (d == 0) ? {1'b0, err0} : (d == 1) ? err1 : err2;
  endfunction

  function automatic logic mdl_vld(input int d);
    return (mq[d].size() > 0) && (mq[d][0].age == lat_of(d));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected fetch result from the address rules using plain 64-bit arithmetic.
  task automatic calc(input logic [63:0] a, input int n, output logic [63:0] ins, output logic [1:0] er);
    logic [63:0] idx;
    ins = '0;
    er  = '0;
    for (int k = 0; k < n; k++) begin
      idx = (a >> 2) + 64'(k);
      if (a[1:0] != 2'b00 || idx >= 64'(MAXI)) begin
        ins[k*32 +: 32] = NOP;
        er[k]           = 1'b1;
      end else begin
        ins[k*32 +: 32] = mmem[idx[7:0]];
      end
    end
  endtask

  task automatic model_edge();
    ent_t e;
    logic mv, st;
    for (int d = 0; d < NDUT; d++) begin
      mv = mdl_vld(d);
      st = mv && !rsp_rdy;
      if (flush) begin
        mq[d].delete();
      end else if (!st) begin
        if (mv) void'(mq[d].pop_front());
        for (int i = 0; i < mq[d].size(); i++) mq[d][i].age = mq[d][i].age + 1;
        if (req_vld) begin
          calc(addr, fn_of(d), e.inst, e.err);
          e.age = 1;
          mq[d].push_back(e);
        end
      end
    end
    if (wr_en) mmem[wr_idx] = wr_data;
  endtask

  task automatic step(input logic rv, input logic [63:0] a, input logic fl, input logic rr,
                      input logic we, input logic [7:0] wi, input logic [31:0] wd);
    logic mv;
    req_vld = rv; addr = a; flush = fl; rsp_rdy = rr;
    wr_en = we; wr_idx = wi; wr_data = wd;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      mv = mdl_vld(d);
      chk($sformatf("d%0d_rsp_vld", d), 64'(get_vld(d)), 64'(mv));
      chk($sformatf("d%0d_req_rdy", d), 64'(get_rdy(d)), 64'(!(mv && !rr)));
      if (mv) begin
        chk($sformatf("d%0d_inst", d), get_inst(d), mq[d][0].inst);
        chk($sformatf("d%0d_err", d), 64'(get_err(d)), 64'(mq[d][0].err));
      end
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rr = 1'b1);
    for (int i = 0; i < n; i++) step(1'b0, 64'h0, 1'b0, rr, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic req(input logic [63:0] a);
    step(1'b1, a, 1'b0, 1'b1, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic reset_checks(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("%s_d%0d_vld", tag, d), 64'(get_vld(d)), 64'h0);
      chk($sformatf("%s_d%0d_inst", tag, d), get_inst(d), 64'h0);
      chk($sformatf("%s_d%0d_err", tag, d), 64'(get_err(d)), 64'h0);
    end
  endtask

  task automatic mid_reset();
    req_vld = 1'b0; flush = 1'b0; wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_checks("arst");
    for (int d = 0; d < NDUT; d++) mq[d].delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] rand_addr();
    int unsigned r = $urandom_range(0, 99);
    if (r < 80) return 64'($urandom_range(0, 257)) << 2;
    if (r < 90) return (64'($urandom_range(0, 257)) << 2) | 64'($urandom_range(1, 3));
    return {$urandom, $urandom};
  endfunction

  initial begin
    rst_n = 1'b1; req_vld = 1'b0; addr = '0; flush = 1'b0; rsp_rdy = 1'b1;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    #1 rst_n = 1'b0;
    #1 reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < MAXI; i++)
      step(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 8'(i),
           (i < 4) ? 32'(32'hA0 + i) : (i == 5) ? 32'h0000_5555 : $urandom);

    // back-to-back fetch
    for (int i = 0; i < 4; i++) req(64'(4 * i));
    idle(10);

    // two-cycle backpressure while responses are pending
    for (int i = 0; i < 4; i++) req(64'(4 * i));
    idle(2, 1'b0);
    idle(10);

    // faults: misaligned, past the end, and straddling the last word
    req(64'h2);
    chk("mis_vld", 64'(vld1), 64'h1);
    chk("mis_inst", inst1, {NOP, NOP});
    chk("mis_err", 64'(err1), 64'h3);
    req(64'(4 * MAXI));
    chk("oob_inst", inst1, {NOP, NOP});
    chk("oob_err", 64'(err1), 64'h3);
    req(64'(4 * (MAXI - 1)));
    chk("edge_inst", inst1, {NOP, mmem[MAXI-1]});
    chk("edge_err", 64'(err1), 64'h2);
    idle(10);

    // flush with a request in the same cycle
    for (int i = 0; i < 3; i++) req(64'(4 * i));
    step(1'b1, 64'd12, 1'b1, 1'b1, 1'b0, 8'h0, 32'h0);
    chk("flush_vld0", 64'(vld0), 64'h0);
    chk("flush_vld1", 64'(vld1), 64'h0);
    idle(3);
    req(64'd16);
    idle(10);

    // read-before-write on a colliding preload
    step(1'b1, 64'd20, 1'b0, 1'b1, 1'b1, 8'd5, 32'h0000_BEEF);
    chk("rbw_old", 64'(inst1[31:0]), 64'h0000_5555);
    chk("rbw_err", 64'(err1), 64'h0);
    idle(10);
    req(64'd20);
    chk("rbw_new", 64'(inst1[31:0]), 64'h0000_BEEF);
    idle(10);

    // asynchronous reset while stalled
    for (int i = 0; i < 3; i++) req(64'(4 * i));
    idle(3, 1'b0);
    mid_reset();
    idle(2);
    req(64'd24);
    idle(10);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) mid_reset();
      step($urandom_range(0, 99) < 70, rand_addr(), $urandom_range(0, 49) == 0,
           $urandom_range(0, 99) < 75, $urandom_range(0, 9) == 0, 8'($urandom), $urandom);
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
